// File: rtl/mac_ctrl_pkg.sv
// Shared types and default sizing for the MAC job sequencer.
package mac_ctrl_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 16;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_SUM_W   = 24;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_PRELOAD,
        S_LOAD,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of every signal between the sequencer, its scheduler, the two
// operand streams and the MAC. master = sequencer view, slave = everything else.
interface mac_seq_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SUM_W  = DEF_SUM_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              x_valid;
    logic              x_ready;
    logic [DATA_W-1:0] x_data;
    logic              mac_clear;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_weight_in;
    logic              mac_preload_weight;
    logic              mac_load_weight;
    logic [DATA_W-1:0] mac_input_val;
    logic [ACC_W-1:0]  mac_out;
    logic              mac_out_valid;
    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_data;
    logic              res_err;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_len, w_valid, w_data, x_valid, x_data,
               mac_out, mac_out_valid, res_ready,
        output cmd_ready, w_ready, x_ready, mac_clear, mac_enable, mac_weight_in,
               mac_preload_weight, mac_load_weight, mac_input_val,
               res_valid, res_data, res_err, busy
    );

    modport slave (
        output cmd_valid, cmd_len, w_valid, w_data, x_valid, x_data,
               mac_out, mac_out_valid, res_ready,
        input  cmd_ready, w_ready, x_ready, mac_clear, mac_enable, mac_weight_in,
               mac_preload_weight, mac_load_weight, mac_input_val,
               res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Job-level sequencer for one INT8 weight-stationary MAC: pulls N weight/input
// pairs, steps the MAC through preload/load/enable per pair, accumulates the
// returned products and hands the sum (or a timeout error) to the scheduler.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a job
// CLEAR   | one-cycle mac_clear pulse
// FETCH   | wait for both streams valid, consume one pair together
// PRELOAD | mac_preload_weight with the fetched weight
// LOAD    | mac_load_weight, weight moves into the active register
// FEED    | mac_enable with the fetched input, timeout timer armed
// WAIT    | wait for mac_out_valid or timer expiry
// DONE    | result held on res_* until res_ready
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int SUM_W   = DEF_SUM_W,
    parameter bit SIGNED  = 1'b1,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] x_lat;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SUM_W-1:0]  mac_ext;
    logic [SUM_W-1:0]  sum_next;
    logic              pair_fire;

    // Widen the MAC product into the accumulator width.
    always_comb begin
        if (SIGNED) begin
            mac_ext = {{(SUM_W - ACC_W){bus.mac_out[ACC_W-1]}}, bus.mac_out};
        end else begin
            mac_ext = {{(SUM_W - ACC_W){1'b0}}, bus.mac_out};
        end
    end

    assign sum_next = sum + mac_ext;

    // Both streams are taken in the same cycle or not at all.
    assign pair_fire   = (state == S_FETCH) && bus.w_valid && bus.x_valid;
    assign bus.w_ready = pair_fire;
    assign bus.x_ready = pair_fire;

    // Sequencer FSM; all MAC strobes and result outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= S_IDLE;
            remaining              <= '0;
            sum                    <= '0;
            x_lat                  <= '0;
            tmo_cnt                <= '0;
            bus.cmd_ready          <= 1'b1;
            bus.busy               <= 1'b0;
            bus.res_valid          <= 1'b0;
            bus.res_data           <= '0;
            bus.res_err            <= 1'b0;
            bus.mac_clear          <= 1'b0;
            bus.mac_enable         <= 1'b0;
            bus.mac_preload_weight <= 1'b0;
            bus.mac_load_weight    <= 1'b0;
            bus.mac_weight_in      <= '0;
            bus.mac_input_val      <= '0;
        end else begin
            bus.mac_clear          <= 1'b0;
            bus.mac_enable         <= 1'b0;
            bus.mac_preload_weight <= 1'b0;
            bus.mac_load_weight    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining     <= bus.cmd_len;
                        sum           <= '0;
                        bus.res_err   <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            bus.res_data  <= '0;
                            bus.res_valid <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            bus.mac_clear <= 1'b1;
                            state         <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (pair_fire) begin
                        // weight goes straight to the MAC bus and is held
                        // there through LOAD; the input waits for FEED
                        bus.mac_weight_in      <= bus.w_data;
                        x_lat                  <= bus.x_data;
                        bus.mac_preload_weight <= 1'b1;
                        state                  <= S_PRELOAD;
                    end
                end
                S_PRELOAD: begin
                    bus.mac_load_weight <= 1'b1;
                    state               <= S_LOAD;
                end
                S_LOAD: begin
                    bus.mac_enable    <= 1'b1;
                    bus.mac_input_val <= x_lat;
                    tmo_cnt           <= TMO_W'(TIMEOUT - 1);
                    state             <= S_FEED;
                end
                S_FEED: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mac_out_valid) begin
                        sum       <= sum_next;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            bus.res_data  <= sum_next;
                            bus.res_valid <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (tmo_cnt == '0) begin
                        bus.res_err   <= 1'b1;
                        bus.res_data  <= sum;
                        bus.res_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 2-cycle MAC, queue-fed
// operand streams and a scoreboard of expected job results.
module tb_mac_seq_ctrl;

    typedef struct {
        logic [23:0] data;
        logic        err;
        int          edges;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mac_mute = 1'b0;
    logic w_en = 1'b1;
    logic x_en = 1'b1;

    logic [7:0] w_q[$];
    logic [7:0] x_q[$];
    exp_t       exp_q[$];

    int errors = 0;
    int checks = 0;
    int w_hs = 0;
    int x_hs = 0;
    int clr_cnt = 0;
    int rdy_cnt = 0;
    int rdy_bad = 0;

    mac_seq_ctrl_if bus ();

    mac_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Behavioural MAC: preload -> load -> enable, signed product valid 2 cycles after enable.
    logic signed [7:0]  m_pre, m_act;
    logic signed [15:0] p1_d, p2_d;
    logic               p1_v, p2_v;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pre <= '0; m_act <= '0; p1_d <= '0; p2_d <= '0; p1_v <= 1'b0; p2_v <= 1'b0;
        end else begin
            if (bus.mac_clear) begin
                m_pre <= '0;
                m_act <= '0;
            end
            if (bus.mac_preload_weight) m_pre <= bus.mac_weight_in;
            if (bus.mac_load_weight) m_act <= m_pre;
            p1_v <= bus.mac_enable;
            p1_d <= m_act * $signed(bus.mac_input_val);
            p2_v <= p1_v && !mac_mute;
            p2_d <= p1_d;
        end
    end

    assign bus.mac_out       = p2_d;
    assign bus.mac_out_valid = p2_v;

    // Operand streams: present queue heads, pop on handshake, watch ready behaviour.
    initial begin
        logic w_fire, x_fire;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.x_valid = 1'b0; bus.x_data = '0;
        forever begin
            @(posedge clk);
            w_fire = bus.w_valid && bus.w_ready;
            x_fire = bus.x_valid && bus.x_ready;
            if (bus.mac_clear) clr_cnt++;
            if (bus.w_ready) rdy_cnt++;
            if ((bus.w_ready !== bus.x_ready) ||
                (bus.w_ready && !(bus.w_valid && bus.x_valid))) rdy_bad++;
            @(negedge clk);
            if (w_fire && w_q.size() > 0) begin w_q.delete(0); w_hs++; end
            if (x_fire && x_q.size() > 0) begin x_q.delete(0); x_hs++; end
            bus.w_valid = w_en && (w_q.size() > 0);
            bus.w_data  = (w_q.size() > 0) ? w_q[0] : 8'h00;
            bus.x_valid = x_en && (x_q.size() > 0);
            bus.x_data  = (x_q.size() > 0) ? x_q[0] : 8'h00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {14'b0, bus.w_ready, bus.x_ready, bus.mac_input_val, bus.mac_weight_in,
                bus.mac_load_weight, bus.mac_preload_weight, bus.mac_enable, bus.mac_clear,
                bus.res_data, bus.res_err, bus.res_valid, bus.busy, bus.cmd_ready};
    endfunction

    task automatic push_pair(input int w, input int x);
        w_q.push_back(8'(w));
        x_q.push_back(8'(x));
    endtask

    // Issue a job; returns 1 time unit after the command handshake edge.
    task automatic issue(input int len, input bit has_res, input logic [23:0] data,
                         input logic err, input int edges);
        exp_t e;
        @(negedge clk);
        w_hs = 0; x_hs = 0; clr_cnt = 0; rdy_cnt = 0; rdy_bad = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        if (has_res) begin
            e.data = data; e.err = err; e.edges = edges;
            exp_q.push_back(e);
        end
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Wait for the next result, compare against the scoreboard, optionally stall res_ready.
    task automatic wait_result(input int hold);
        exp_t e;
        int   edges = 0;
        bit   seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1 edges++;
        end
        check("res_valid_seen", 64'(seen), 64'd1);
        check("sb_pending", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        if (!seen) return;
        if (e.edges >= 0) check("latency", 64'(edges), 64'(e.edges));
        check("res_data", 64'(bus.res_data), 64'(e.data));
        check("res_err", 64'(bus.res_err), 64'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 check("hold_stable", 64'({bus.res_valid, bus.res_err, bus.res_data, bus.cmd_ready}),
                     64'({1'b1, e.err, e.data, 1'b0}));
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        check("back_to_idle", 64'({bus.res_valid, bus.cmd_ready, bus.busy}), 64'(3'b010));
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.res_ready = 1'b0;

        #12 check("reset_outputs", out_vec(), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic dot product: 2*5 - 3*6 - 4 = -12; 1+1+3*6+1 = 21 cycles -> 19 edges after handshake.
        push_pair(2, 5); push_pair(-3, 6); push_pair(4, -1);
        issue(3, 1'b1, 24'hFFFFF4, 1'b0, 19);
        wait_result(0);
        check("basic_clear_pulses", 64'(clr_cnt), 64'd1);
        check("basic_w_beats", 64'(w_hs), 64'd3);
        check("basic_x_beats", 64'(x_hs), 64'd3);

        // Zero length with a pair on offer: nothing consumed, result visible next cycle.
        push_pair(9, 9);
        issue(0, 1'b1, 24'h000000, 1'b0, 0);
        wait_result(0);
        check("zero_clear_pulses", 64'(clr_cnt), 64'd0);
        check("zero_w_beats", 64'(w_hs), 64'd0);
        check("zero_x_beats", 64'(x_hs), 64'd0);
        @(negedge clk);
        w_q.delete(); x_q.delete();

        // Skew: x stream held off for 5 cycles. -7*9 + 10*-3 = -93.
        x_en = 1'b0;
        push_pair(-7, 9); push_pair(10, -3);
        issue(2, 1'b1, 24'hFFFFA3, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("skew_no_early_beat", 64'(w_hs), 64'd0);
        check("skew_w_ready_low", 64'(bus.w_ready), 64'd0);
        x_en = 1'b1;
        wait_result(0);
        check("skew_ready_cycles", 64'(rdy_cnt), 64'd2);
        check("skew_ready_pairing", 64'(rdy_bad), 64'd0);
        check("skew_w_beats", 64'(w_hs), 64'd2);

        // Timeout: MAC silent; 1+1+4+15+1 = 22 cycles -> 20 edges, second pair untouched.
        mac_mute = 1'b1;
        push_pair(3, 3); push_pair(4, 4);
        issue(2, 1'b1, 24'h000000, 1'b1, 20);
        wait_result(0);
        check("timeout_w_beats", 64'(w_hs), 64'd1);
        check("timeout_x_beats", 64'(x_hs), 64'd1);
        @(negedge clk);
        mac_mute = 1'b0;
        w_q.delete(); x_q.delete();

        // Backpressure: 127*127 - 1 = 16128; 1+1+2*6+1 = 15 cycles -> 13 edges; hold 10 cycles.
        push_pair(127, 127); push_pair(-1, 1);
        issue(2, 1'b1, 24'h003F00, 1'b0, 13);
        wait_result(10);

        // Reset in WAIT of an abandoned job: outputs drop to reset values at once.
        push_pair(5, 5);
        issue(1, 1'b0, 24'h0, 1'b0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 64'({bus.busy, bus.mac_weight_in}), 64'({1'b1, 8'h05}));
        reset = 1'b1;
        #1 check("mid_job_reset_outputs", out_vec(), 64'd1);
        w_q.delete(); x_q.delete();
        @(negedge clk);
        reset = 1'b0;

        // -128 * -128 = 16384; 1+1+6+1 = 9 cycles -> 7 edges.
        push_pair(-128, -128);
        issue(1, 1'b1, 24'h004000, 1'b0, 7);
        wait_result(0);
        check("final_w_beats", 64'(w_hs), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
